// File: rtl/hit_writer.sv
// rtl/hit_writer.sv - stores one multi-word record as a burst of 16-bit AVMM writes
//
// Purpose:
//   Accepts a record of NDWORDS 32-bit words and writes it to memory as
//   2*NDWORDS consecutive 16-bit Avalon-MM writes, lowest halfword first.
//   The record lands at baseaddr + index*NDWORDS*4 (32-bit wrapping).
//
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous active-high reset
//   baseaddr[31:0]      byte base address of the record array (sampled on accept)
//   index[31:0]         record index (sampled on accept)
//   write               request to store one record
//   data[32*NDWORDS-1:0] record payload, word k at data[32k+31:32k] (sampled on accept)
//   iready              high when a request can be accepted this cycle
//   odone               one-cycle pulse after the last halfword is accepted
//   avm_m0_write        AVMM write strobe
//   avm_m0_address      AVMM byte address
//   avm_m0_writedata    AVMM write data (16 bits)
//   avm_m0_byteenable   AVMM byte enables (always both lanes)
//   avm_m0_waitrequest  AVMM stall from the slave

module hit_writer #(
    parameter int NDWORDS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            baseaddr,
    input  logic [31:0]            index,
    input  logic                   write,
    input  logic [32*NDWORDS-1:0]  data,
    output logic                   iready,
    output logic                   odone,
    output logic                   avm_m0_write,
    output logic [31:0]            avm_m0_address,
    output logic [15:0]            avm_m0_writedata,
    output logic [1:0]             avm_m0_byteenable,
    input  logic                   avm_m0_waitrequest
);

    localparam int NHALF = 2 * NDWORDS;
    localparam int HW    = (NHALF > 1) ? $clog2(NHALF) : 1;

    localparam logic [HW-1:0] LAST_H    = HW'(NHALF - 1);
    localparam logic [31:0]   REC_BYTES = 32'(NDWORDS * 4);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t state, state_nxt;

    logic                  accept;
    logic                  hw_accept;
    logic                  last_hw;
    logic [HW-1:0]         h;
    logic [32*NDWORDS-1:0] shreg;
    logic [31:0]           rec_addr;

    // 32-bit product and sum deliberately truncate: the address space wraps.
    assign rec_addr = baseaddr + index * REC_BYTES;

    assign last_hw           = (h == LAST_H);
    assign avm_m0_byteenable = 2'b11;

    // The captured record is shifted down one halfword per accepted write,
    // so the current halfword is always at the bottom of the register.
    assign avm_m0_writedata  = shreg[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        iready       = 1'b0;
        avm_m0_write = 1'b0;
        accept       = 1'b0;
        hw_accept    = 1'b0;
        case (state)
            IDLE: begin
                iready = 1'b1;
                accept = write;
                if (write) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                avm_m0_write = 1'b1;
                hw_accept    = !avm_m0_waitrequest;
                if (hw_accept && last_hw) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h              <= '0;
            shreg          <= '0;
            avm_m0_address <= '0;
            odone          <= 1'b0;
        end else begin
            odone <= hw_accept && last_hw;
            if (accept) begin
                h              <= '0;
                shreg          <= data;
                avm_m0_address <= rec_addr;
            end else if (hw_accept && !last_hw) begin
                // After the final halfword the address and data are left
                // alone so the bus values simply hold while idle.
                h              <= h + HW'(1);
                shreg          <= {16'h0000, shreg[32*NDWORDS-1:16]};
                avm_m0_address <= avm_m0_address + 32'd2;
            end
        end
    end

endmodule

// File: tb/tb_hit_writer.sv
// tb/tb_hit_writer.sv - directed self-checking bench for hit_writer

module tb_hit_writer;

    logic        clk;
    logic        reset;
    logic [31:0] baseaddr;
    logic [31:0] index;
    logic        write;
    logic [95:0] data;
    logic        iready;
    logic        odone;
    logic        avm_m0_write;
    logic [31:0] avm_m0_address;
    logic [15:0] avm_m0_writedata;
    logic [1:0]  avm_m0_byteenable;
    logic        avm_m0_waitrequest;

    int nvec;
    int nerr;

    hit_writer #(.NDWORDS(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .baseaddr           (baseaddr),
        .index              (index),
        .write              (write),
        .data               (data),
        .iready             (iready),
        .odone              (odone),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_address     (avm_m0_address),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_byteenable  (avm_m0_byteenable),
        .avm_m0_waitrequest (avm_m0_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one record and walks it through the bus, checking every cycle.
    // Ends in the cycle where odone should be high (no clock step after it).
    task automatic run_record(input logic [31:0] b, input logic [31:0] i,
                              input logic [95:0] d, input logic [31:0] ea,
                              input int stall_h, input int stall_n,
                              input bit repulse);
        logic [31:0] a;
        baseaddr = b;
        index    = i;
        data     = d;
        write    = 1'b1;
        chk("accept_iready", 32'(iready), 32'd1);
        step();
        write    = 1'b0;
        // Scramble inputs to prove they were sampled at accept.
        baseaddr = 32'hDEAD_0000;
        index    = 32'h0000_0077;
        data     = '1;
        for (int k = 0; k < 6; k++) begin
            a = ea + 32'(2 * k);
            for (int s = 0; s < ((k == stall_h) ? stall_n : 0); s++) begin
                avm_m0_waitrequest = 1'b1;
                write              = 1'b0;
                chk("stall_write", 32'(avm_m0_write), 32'd1);
                chk("stall_addr", avm_m0_address, a);
                chk("stall_data", 32'(avm_m0_writedata), 32'(d[16*k +: 16]));
                chk("stall_odone", 32'(odone), 32'd0);
                step();
            end
            avm_m0_waitrequest = 1'b0;
            write = repulse && (k == 1);
            chk("hw_write", 32'(avm_m0_write), 32'd1);
            chk("hw_addr", avm_m0_address, a);
            chk("hw_data", 32'(avm_m0_writedata), 32'(d[16*k +: 16]));
            chk("hw_be", 32'(avm_m0_byteenable), 32'd3);
            chk("hw_odone", 32'(odone), 32'd0);
            chk("hw_iready", 32'(iready), 32'd0);
            step();
        end
        write = 1'b0;
        chk("done_odone", 32'(odone), 32'd1);
        chk("done_write", 32'(avm_m0_write), 32'd0);
        chk("done_iready", 32'(iready), 32'd1);
    endtask

    initial begin
        logic [95:0] d1;
        logic [95:0] d2;
        nvec = 0;
        nerr = 0;
        d1 = {32'h0000_0005, 32'h0001_2000, 32'h0000_0001};
        d2 = {32'hCCCC_DDDD, 32'hAAAA_BBBB, 32'h1234_5678};

        reset              = 1'b1;
        baseaddr           = '0;
        index              = '0;
        write              = 1'b0;
        data               = '0;
        avm_m0_waitrequest = 1'b0;
        #12;
        chk("rst_write", 32'(avm_m0_write), 32'd0);
        chk("rst_odone", 32'(odone), 32'd0);
        chk("rst_addr", avm_m0_address, 32'd0);
        chk("rst_data", 32'(avm_m0_writedata), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_iready", 32'(iready), 32'd1);
        chk("rst_be", 32'(avm_m0_byteenable), 32'd3);
        step();

        // Basic record at 0x1000 + 2*12
        run_record(32'h1000, 32'd2, d1, 32'h1018, -1, 0, 1'b0);
        step();
        chk("t1_odone_once", 32'(odone), 32'd0);
        chk("t1_idle_write", 32'(avm_m0_write), 32'd0);

        // Three waitrequest cycles on halfword 2
        run_record(32'h1000, 32'd2, d1, 32'h1018, 2, 3, 1'b0);
        step();
        chk("t2_odone_once", 32'(odone), 32'd0);

        // Second write pulse mid-record must be dropped
        run_record(32'h1000, 32'd2, d1, 32'h1018, -1, 0, 1'b1);
        step();
        chk("t3_odone_once", 32'(odone), 32'd0);
        chk("t3_no_extra", 32'(avm_m0_write), 32'd0);
        step();
        chk("t3_no_extra2", 32'(avm_m0_write), 32'd0);

        // Back-to-back records, second accepted in the odone cycle
        run_record(32'h1000, 32'd0, d2, 32'h1000, -1, 0, 1'b0);
        run_record(32'h1000, 32'd1, d1, 32'h100C, -1, 0, 1'b0);
        step();
        chk("t4_odone_once", 32'(odone), 32'd0);

        // Reset after halfword 3 accepted
        baseaddr = 32'h1000;
        index    = 32'd2;
        data     = d1;
        write    = 1'b1;
        step();
        write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t5_addr", avm_m0_address, 32'h1018 + 32'(2 * k));
            step();
        end
        chk("t5_hw4_write", 32'(avm_m0_write), 32'd1);
        chk("t5_hw4_addr", avm_m0_address, 32'h1020);
        reset = 1'b1;
        #1;
        chk("t5_abort_write", 32'(avm_m0_write), 32'd0);
        chk("t5_abort_addr", avm_m0_address, 32'd0);
        chk("t5_abort_odone", 32'(odone), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_rel_iready", 32'(iready), 32'd1);
        chk("t5_rel_odone", 32'(odone), 32'd0);
        step();
        chk("t5_quiet_write", 32'(avm_m0_write), 32'd0);
        chk("t5_quiet_odone", 32'(odone), 32'd0);
        run_record(32'h1000, 32'd1, d2, 32'h100C, -1, 0, 1'b0);
        step();

        // Base address wraps past 2^32
        run_record(32'hFFFF_FFF8, 32'd0, d1, 32'hFFFF_FFF8, -1, 0, 1'b0);
        step();

        // index*12 = 2^32*3 wraps to zero offset
        run_record(32'h1000, 32'h4000_0000, d2, 32'h1000, 0, 1, 1'b0);
        step();
        chk("t7_odone_once", 32'(odone), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hit_writer.md
HIT_WRITER -- requirements
Module: hit_writer

Interface
REQ-001 Parameter NDWORDS, default 3: number of 32-bit words per record.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 baseaddr  input  32  byte base address of record array; sampled on accept.
REQ-005 index  input  32  record index; sampled on accept.
REQ-006 write  input  1  request to store one record.
REQ-007 data  input  32*NDWORDS  record payload, word k = data[32k+31:32k]; sampled on accept.
REQ-008 iready  output  1  block can accept a request this cycle.
REQ-009 odone  output  1  one-cycle pulse when the last halfword of a record is accepted by the slave.
REQ-010 avm_m0_write  output  1  AVMM write strobe.
REQ-011 avm_m0_address  output  32  AVMM byte address.
REQ-012 avm_m0_writedata  output  16  AVMM write data.
REQ-013 avm_m0_byteenable  output  2  AVMM byte enables.
REQ-014 avm_m0_waitrequest  input  1  AVMM stall from slave.

Function
REQ-015 States: IDLE, WRITE; iready SHALL equal (state==IDLE).
REQ-016 Accept = write && iready; on accept, capture data, compute record address A = baseaddr + index*NDWORDS*4 (mod 2^32), clear halfword counter h, enter WRITE next cycle.
REQ-017 write while not iready SHALL be ignored; no queuing.
REQ-018 In WRITE: avm_m0_write=1, avm_m0_address=A+2h, avm_m0_writedata = halfword h of captured data (h=0 -> data[15:0], h=1 -> data[31:16], ascending), avm_m0_byteenable=2'b11.
REQ-019 Address, writedata and write SHALL stay stable while avm_m0_waitrequest=1.
REQ-020 Halfword h accepted when avm_m0_write && !avm_m0_waitrequest; then h increments.
REQ-021 On acceptance of h = 2*NDWORDS-1: return to IDLE next cycle, avm_m0_write=0, odone=1 for exactly that one cycle.
REQ-022 Timing with waitrequest=0: accept at cycle N -> avm_m0_write high cycles N+1..N+2*NDWORDS -> odone and iready high at N+2*NDWORDS+1; each waitrequest cycle adds one cycle.
REQ-023 A new accept is allowed in the cycle odone is high (back-to-back records: 2*NDWORDS+1 cycles per record).
REQ-024 In IDLE: avm_m0_write=0, avm_m0_byteenable=2'b11, address/writedata hold last value (don't-care).
REQ-025 Address arithmetic is 32-bit unsigned, wrapping at 2^32.

Reset
REQ-026 reset asserts asynchronously: state=IDLE, h=0, avm_m0_write=0, odone=0, avm_m0_address=0, avm_m0_writedata=0, iready=1 once reset deasserts (0 not required during reset).
REQ-027 reset during WRITE aborts the record immediately; no further halfwords, no odone.
REQ-028 No request is accepted in a cycle where reset is high.

Verification
REQ-029 NDWORDS=3, baseaddr=0x1000, index=2, data={0x00000005,0x00012000,0x00000001}, waitrequest=0 -> writes at 0x1018..0x1022 step 2 with data 0x0001,0x0000,0x2000,0x0001,0x0005,0x0000; odone 7 cycles after accept.
REQ-030 Same record, waitrequest=1 for 3 cycles on halfword 2 -> address 0x101C and data 0x2000 held those 3 cycles; odone at cycle 10.
REQ-031 write pulsed again 2 cycles after accept -> ignored; exactly 6 AVMM writes, one odone.
REQ-032 Two back-to-back records (index 0 then 1, second write asserted during odone) -> 12 writes, addresses 0x1000..0x1016 contiguous, two odone pulses 7 cycles apart.
REQ-033 reset asserted after halfword 3 accepted -> avm_m0_write low in same cycle, no odone, iready=1 after release; next record writes correctly.
REQ-034 baseaddr=0xFFFFFFF8, index=0 -> addresses 0xFFFFFFF8..0x00000002 wrap.
